pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Hazard and forwarding controller for the 5-stage pipeline (IF, ID, EX, MEM, WB).
- Tracks in-flight destination registers in a shadow scoreboard aligned with the ID/EX, EX/MEM and MEM/WB registers.
- Generates registered forwarding selects for the EX operand muxes, load-use stalls, and branch flushes.
- Sits beside the decoder; its outputs drive the PC enable, the IF/ID hold/clear, the ID/EX bubble insert and the EX operand muxes.

Parameters:
- REG_AW, 4, register address width.
- CNT_W, 16, width of the performance counters (used only with the optional feature).

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_rn  in  REG_AW  ID source A register.
- id_rn_en  in  1  source A is read.
- id_rm  in  REG_AW  ID source B register.
- id_rm_en  in  1  source B is read (0 when the immediate is selected).
- id_rd  in  REG_AW  ID destination register.
- id_wb_en  in  1  ID instruction writes back.
- id_ld  in  1  ID instruction is a load (data comes from memory in MEM).
- ex_br  in  1  branch taken, resolved in EX this cycle.
- pc_stall  out  1  hold the PC.
- ifid_stall  out  1  hold IF/ID.
- ifid_flush  out  1  clear IF/ID to NOP at the next edge.
- idex_bubble  out  1  load a NOP into ID/EX at the next edge.
- fwd_a_sel  out  2  EX operand A select: 00 regfile, 01 EX/MEM ALU result, 10 MEM/WB writeback data.
- fwd_b_sel  out  2  EX operand B select, same encoding.
- stall_cnt  out  CNT_W  load-use stall cycles.
- flush_cnt  out  CNT_W  taken-branch flushes.

Behaviour:
- Scoreboard slots S_EX, S_MEM, S_WB; each holds {valid, rd, ld}.
- Every edge: S_WB<=S_MEM; S_MEM<=S_EX.
- S_EX<={id_wb_en & id_valid, id_rd, id_ld}, or invalid when idex_bubble=1.
- id_valid = 0 in state FLUSH, else 1.
- Source match: src_en & id_valid & slot.valid & (slot.rd==src).
- Load-use hazard (luh): an enabled source matches S_EX with S_EX.ld=1.
- Forwarding is computed in ID and registered into fwd_*_sel, so the selects are valid during the consumer's EX cycle.
  - Match S_EX (non-load) -> 01.
  - Else match S_MEM -> 10.
  - Else 00.
  - Youngest producer wins.
  - A match on S_WB needs no forward: the regfile write is done by then.
- In a stall cycle, fwd_*_sel registers 00 (the bubble).
- After a load-use stall, the load sits in S_MEM, so the consumer gets 10 on its next ID evaluation.
- FSM states, in RUN, with ex_br taking priority over luh:
  - ex_br=1: ifid_flush=1, idex_bubble=1, no stall; go to FLUSH. A stall request in the same cycle is discarded, because the ID instruction is squashed.
  - luh=1: pc_stall=ifid_stall=idex_bubble=1; go to LDSTALL.
  - Otherwise stay in RUN; all control outputs 0.
- LDSTALL (1 cycle): re-evaluate luh, which is now 0 since the load has moved to S_MEM.
  - ex_br=1 is impossible here because EX holds the bubble; if it is asserted anyway, treat it as in RUN.
  - Go to RUN.
- FLUSH (1 cycle): ID holds the flushed NOP; id_valid=0, so no hazards and the S_EX entry is invalid.
  - ex_br is ignored here, because EX holds the bubble.
  - Go to RUN.
- Stall and flush outputs are combinational from state and inputs; no extra latency.
- Reset (asynchronous): state RUN, all slots invalid, fwd_*_sel=00, counters 0, all control outputs 0.
- Reset mid-stall or mid-flush returns to RUN immediately.
- Register 4'hF gets no special treatment.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined:
  - stall_cnt increments on each cycle with pc_stall=1.
  - flush_cnt increments on each ex_br accepted in RUN.
  - Both saturate at all-ones.
- Undefined: both outputs are tied to 0 and no counter flops exist.

Decomposition:
- Shared package hazard_pkg holds:
  - the FSM state encoding (RUN=2'd0, LDSTALL=2'd1, FLUSH=2'd2);
  - the forwarding-select constants FWD_RF=2'b00, FWD_EXM=2'b01, FWD_MWB=2'b10;
  - the scoreboard slot struct.
- One sub-module is natural: fwd_match, combinational priority compare of one source against S_EX/S_MEM, instantiated twice (A and B).

Test Plan:
- ALU RAW:
  - Stimulus: ADD r1 in ID, next cycle SUB with rn=r1.
  - Response: fwd_a_sel=01 in SUB's EX; no stall.
- Distance-2 RAW:
  - Stimulus: writer r2, one independent instruction, then reader rm=r2.
  - Response: fwd_b_sel=10; reader with rm_en=0 gives 00.
- Load-use:
  - Stimulus: LDR r3, then ADD rn=r3.
  - Response: one cycle pc_stall=ifid_stall=idex_bubble=1; then fwd_a_sel=10; stall_cnt=1 with the macro.
- Priority:
  - Stimulus: back-to-back writers to r4 (older in S_MEM, newer in S_EX), reader in ID.
  - Response: fwd=01.
- Branch:
  - Stimulus: ex_br=1 while ID holds a load-use consumer.
  - Response: ifid_flush=1, idex_bubble=1, pc_stall=0; next cycle FLUSH with no hazard outputs; then RUN; flush_cnt=1.
- Reset:
  - Stimulus: assert rst during LDSTALL.
  - Response: outputs 0 immediately; scoreboard cleared, so a following reader of the same register gets fwd=00.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard/forwarding controller: FSM encoding,
// forwarding-select constants and the in-flight scoreboard slot.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LDSTALL = 2'd1,
    FLUSH   = 2'd2
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EXM = 2'b01;
  localparam logic [1:0] FWD_MWB = 2'b10;

  // Slot rd is stored at a fixed maximum width so the struct stays
  // non-parametric; register addresses are zero-extended into it.
  localparam int RD_MAX_W = 8;

  typedef struct packed {
    logic                valid;
    logic [RD_MAX_W-1:0] rd;
    logic                ld;
  } slot_t;

  localparam slot_t SLOT_EMPTY = '{valid: 1'b0, rd: '0, ld: 1'b0};

  typedef enum int {
    S_EX  = 0,
    S_MEM = 1,
    S_WB  = 2
  } slot_idx_t;

  localparam int SLOT_N = 3;

  function automatic slot_t make_slot(input logic valid,
                                      input logic [RD_MAX_W-1:0] rd,
                                      input logic ld);
    slot_t s;
    s.valid = valid;
    s.rd    = rd;
    s.ld    = valid & ld;
    return s;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Decoder-side bundle of the hazard controller: ID operand/destination info,
// the EX branch-taken strobe, and the stall/flush/forwarding/counter returns.
interface pipe_hazard_ctrl_if #(
  parameter int REG_AW = 4,
  parameter int CNT_W  = 16
);

  logic [REG_AW-1:0] id_rn;
  logic              id_rn_en;
  logic [REG_AW-1:0] id_rm;
  logic              id_rm_en;
  logic [REG_AW-1:0] id_rd;
  logic              id_wb_en;
  logic              id_ld;
  logic              ex_br;

  logic              pc_stall;
  logic              ifid_stall;
  logic              ifid_flush;
  logic              idex_bubble;
  logic [1:0]        fwd_a_sel;
  logic [1:0]        fwd_b_sel;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output id_rn, id_rn_en, id_rm, id_rm_en, id_rd, id_wb_en, id_ld, ex_br,
    input  pc_stall, ifid_stall, ifid_flush, idex_bubble,
    input  fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rn, id_rn_en, id_rm, id_rm_en, id_rd, id_wb_en, id_ld, ex_br,
    output pc_stall, ifid_stall, ifid_flush, idex_bubble,
    output fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/pipe_hazard_ctrl_fwd_match.sv
// Priority compare of one ID source against the S_EX and S_MEM scoreboard
// slots; yields the unregistered forward select and a load-use hit.
module fwd_match
  import hazard_pkg::*;
#(
  parameter int REG_AW = 4
) (
  input  logic [REG_AW-1:0]   src,
  input  logic                src_en,
  input  logic                id_valid,
  input  slot_t               s_ex,
  input  logic                mem_valid,
  input  logic [RD_MAX_W-1:0] mem_rd,
  output logic [1:0]          fwd_sel,
  output logic                luh
);

  logic [RD_MAX_W-1:0] src_x;
  logic                hit_ex;
  logic                hit_mem;

  assign src_x   = RD_MAX_W'(src);
  assign hit_ex  = src_en & id_valid & s_ex.valid & (s_ex.rd == src_x);
  assign hit_mem = src_en & id_valid & mem_valid & (mem_rd == src_x);
  assign luh     = hit_ex & s_ex.ld;

  // A load in S_EX is the youngest producer; its data is not ready yet, so
  // an older S_MEM copy must not be selected in its place.
  always_comb begin
    // NOTE: assign every always_comb output a default first so no path
    // leaves it unassigned and a latch is inferred.
    fwd_sel = FWD_RF;
    if (hit_ex) begin
      fwd_sel = s_ex.ld ? FWD_RF : FWD_EXM;
    end else if (hit_mem) begin
      fwd_sel = FWD_MWB;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller for the 5-stage pipeline: shadow scoreboard,
// load-use stall and branch-flush FSM, registered EX forward selects.
// Optional stall/flush performance counters: define HAZARD_PERF_CNT_EN.
module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW = 4,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  pipe_hazard_ctrl_if.slave      hz
);

  state_t     state_q;
  state_t     state_d;
  slot_t      sb [SLOT_N];
  logic       id_valid;
  logic [1:0] fwd_a_d;
  logic [1:0] fwd_b_d;
  logic [1:0] fwd_a_q;
  logic [1:0] fwd_b_q;
  logic       luh_a;
  logic       luh_b;
  logic       luh;
  logic       pc_stall;
  logic       ifid_stall;
  logic       ifid_flush;
  logic       idex_bubble;

  // The instruction in ID during FLUSH is the squashed NOP.
  assign id_valid = (state_q != FLUSH);

  fwd_match #(.REG_AW(REG_AW)) u_fwd_a (
    .src       (hz.id_rn),
    .src_en    (hz.id_rn_en),
    .id_valid  (id_valid),
    .s_ex      (sb[S_EX]),
    .mem_valid (sb[S_MEM].valid),
    .mem_rd    (sb[S_MEM].rd),
    .fwd_sel   (fwd_a_d),
    .luh       (luh_a)
  );

  fwd_match #(.REG_AW(REG_AW)) u_fwd_b (
    .src       (hz.id_rm),
    .src_en    (hz.id_rm_en),
    .id_valid  (id_valid),
    .s_ex      (sb[S_EX]),
    .mem_valid (sb[S_MEM].valid),
    .mem_rd    (sb[S_MEM].rd),
    .fwd_sel   (fwd_b_d),
    .luh       (luh_b)
  );

  assign luh = luh_a | luh_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      state_q <= state_d;
    end
  end

  // LDSTALL behaves like RUN: luh is normally already clear, and a stray
  // ex_br is honoured the same way.
  always_comb begin
    state_d     = RUN;
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    unique case (state_q)
      RUN, LDSTALL: begin
        if (hz.ex_br) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          state_d     = FLUSH;
        end else if (luh) begin
          pc_stall    = 1'b1;
          ifid_stall  = 1'b1;
          idex_bubble = 1'b1;
          state_d     = LDSTALL;
        end
      end
      FLUSH:   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Scoreboard shifts every edge; a bubble enters S_EX as an empty slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the scoreboard is a handful of flops whose valid bits gate
      // hazard detection, so it is reset explicitly, unlike a RAM array.
      for (int i = 0; i < SLOT_N; i++) begin
        sb[i] <= SLOT_EMPTY;
      end
    end else begin
      sb[S_WB]  <= sb[S_MEM];
      sb[S_MEM] <= sb[S_EX];
      sb[S_EX]  <= idex_bubble ? SLOT_EMPTY
                               : make_slot(hz.id_wb_en & id_valid,
                                           RD_MAX_W'(hz.id_rd), hz.id_ld);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else begin
      fwd_a_q <= idex_bubble ? FWD_RF : fwd_a_d;
      fwd_b_q <= idex_bubble ? FWD_RF : fwd_b_d;
    end
  end

  assign hz.pc_stall    = pc_stall;
  assign hz.ifid_stall  = ifid_stall;
  assign hz.ifid_flush  = ifid_flush;
  assign hz.idex_bubble = idex_bubble;
  assign hz.fwd_a_sel   = fwd_a_q;
  assign hz.fwd_b_sel   = fwd_b_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  // Saturating counters; ifid_flush is only raised for an accepted branch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (pc_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if (ifid_flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
        flush_cnt_q <= flush_cnt_q + 1'b1;
      end
    end
  end

  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;
`else
  assign hz.stall_cnt = {CNT_W{1'b0}};
  assign hz.flush_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: RAW forwarding, load-use stall,
// branch flush, producer priority and mid-stall reset.
module tb_pipe_hazard_ctrl;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  pipe_hazard_ctrl_if #(.REG_AW(4), .CNT_W(16)) hz ();

  pipe_hazard_ctrl #(.REG_AW(4), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic [3:0] rn, input logic rn_en,
                       input logic [3:0] rm, input logic rm_en,
                       input logic [3:0] rd, input logic wb,
                       input logic ld, input logic br);
    hz.id_rn    = rn;
    hz.id_rn_en = rn_en;
    hz.id_rm    = rm;
    hz.id_rm_en = rm_en;
    hz.id_rd    = rd;
    hz.id_wb_en = wb;
    hz.id_ld    = ld;
    hz.ex_br    = br;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    instr(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

    // Reset state
    #1;
    chk("rst_pc_stall",    hz.pc_stall,    1'b0);
    chk("rst_ifid_stall",  hz.ifid_stall,  1'b0);
    chk("rst_ifid_flush",  hz.ifid_flush,  1'b0);
    chk("rst_idex_bubble", hz.idex_bubble, 1'b0);
    chk("rst_fwd_a",       hz.fwd_a_sel,   2'b00);
    chk("rst_fwd_b",       hz.fwd_b_sel,   2'b00);
    chk("rst_stall_cnt",   hz.stall_cnt,   16'd0);
    chk("rst_flush_cnt",   hz.flush_cnt,   16'd0);
    tick();
    tick();
    rst = 1'b0;

    // ALU RAW: ADD r1 then SUB rn=r1
    instr(4'd0, 1'b0, 4'd0, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0);
    tick();
    instr(4'd1, 1'b1, 4'd5, 1'b1, 4'd6, 1'b1, 1'b0, 1'b0);
    #1;
    chk("alu_no_stall",  hz.pc_stall,    1'b0);
    chk("alu_no_bubble", hz.idex_bubble, 1'b0);
    tick();
    chk("alu_fwd_a_exm", hz.fwd_a_sel, 2'b01);
    chk("alu_fwd_b_rf",  hz.fwd_b_sel, 2'b00);

    // Distance-2 RAW: writer r2, independent, reader rm=r2
    instr(4'd0, 1'b0, 4'd0, 1'b0, 4'd2, 1'b1, 1'b0, 1'b0);
    tick();
    instr(4'd8, 1'b1, 4'd0, 1'b0, 4'd7, 1'b1, 1'b0, 1'b0);
    tick();
    chk("d2_indep_fwd_a", hz.fwd_a_sel, 2'b00);
    instr(4'd9, 1'b1, 4'd2, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("d2_fwd_b_mwb", hz.fwd_b_sel, 2'b10);
    chk("d2_fwd_a_rf",  hz.fwd_a_sel, 2'b00);

    // Same distance, but rm not read (immediate operand)
    instr(4'd0, 1'b0, 4'd0, 1'b0, 4'd2, 1'b1, 1'b0, 1'b0);
    tick();
    instr(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    tick();
    instr(4'd0, 1'b0, 4'd2, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("d2_rm_dis_fwd_b", hz.fwd_b_sel, 2'b00);
    // r2 producer now only in S_WB: regfile already written
    instr(4'd0, 1'b0, 4'd2, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("wb_no_forward", hz.fwd_b_sel, 2'b00);

    // Load-use: LDR r3 then ADD rn=r3
    instr(4'd0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0);
    tick();
    instr(4'd3, 1'b1, 4'd0, 1'b0, 4'd11, 1'b1, 1'b0, 1'b0);
    #1;
    chk("lu_pc_stall",    hz.pc_stall,    1'b1);
    chk("lu_ifid_stall",  hz.ifid_stall,  1'b1);
    chk("lu_idex_bubble", hz.idex_bubble, 1'b1);
    chk("lu_no_flush",    hz.ifid_flush,  1'b0);
    tick();
    chk("lu_bubble_fwd_a", hz.fwd_a_sel, 2'b00);
    chk("lu_stall_cnt",    hz.stall_cnt, PERF ? 16'd1 : 16'd0);
    #1;
    chk("lu_release_stall",  hz.pc_stall,    1'b0);
    chk("lu_release_bubble", hz.idex_bubble, 1'b0);
    tick();
    chk("lu_fwd_a_mwb", hz.fwd_a_sel, 2'b10);

    // Priority: two writers of r4, reader of r4 picks the younger
    instr(4'd0, 1'b0, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0);
    tick();
    instr(4'd0, 1'b0, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0);
    tick();
    instr(4'd4, 1'b1, 4'd4, 1'b1, 4'd15, 1'b1, 1'b0, 1'b0);
    tick();
    chk("prio_fwd_a", hz.fwd_a_sel, 2'b01);
    chk("prio_fwd_b", hz.fwd_b_sel, 2'b01);
    // r15 in S_EX, r4 in S_MEM
    instr(4'd15, 1'b1, 4'd4, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("r15_fwd_a_exm", hz.fwd_a_sel, 2'b01);
    chk("r4_fwd_b_mwb",  hz.fwd_b_sel, 2'b10);

    // Branch taken while ID holds a load-use consumer
    instr(4'd0, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 1'b1, 1'b0);
    tick();
    instr(4'd5, 1'b1, 4'd0, 1'b0, 4'd6, 1'b1, 1'b0, 1'b1);
    #1;
    chk("br_ifid_flush",  hz.ifid_flush,  1'b1);
    chk("br_idex_bubble", hz.idex_bubble, 1'b1);
    chk("br_pc_stall",    hz.pc_stall,    1'b0);
    chk("br_ifid_stall",  hz.ifid_stall,  1'b0);
    tick();
    chk("br_fwd_a",     hz.fwd_a_sel, 2'b00);
    chk("br_flush_cnt", hz.flush_cnt, PERF ? 16'd1 : 16'd0);
    // FLUSH: squashed ID and a stray ex_br must both be ignored
    instr(4'd5, 1'b1, 4'd0, 1'b0, 4'd6, 1'b1, 1'b1, 1'b1);
    #1;
    chk("fl_ifid_flush",  hz.ifid_flush,  1'b0);
    chk("fl_idex_bubble", hz.idex_bubble, 1'b0);
    chk("fl_pc_stall",    hz.pc_stall,    1'b0);
    tick();
    chk("fl_no_forward", hz.fwd_a_sel, 2'b00);
    chk("fl_flush_cnt",  hz.flush_cnt, PERF ? 16'd1 : 16'd0);
    // Back in RUN: the FLUSH-cycle load to r6 must not be in S_EX
    instr(4'd6, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("post_fl_no_stall", hz.pc_stall, 1'b0);
    tick();
    chk("post_fl_fwd_a",     hz.fwd_a_sel, 2'b00);
    chk("post_fl_stall_cnt", hz.stall_cnt, PERF ? 16'd1 : 16'd0);

    // Reset asserted during LDSTALL
    instr(4'd0, 1'b0, 4'd0, 1'b0, 4'd12, 1'b1, 1'b1, 1'b0);
    tick();
    instr(4'd12, 1'b1, 4'd0, 1'b0, 4'd13, 1'b1, 1'b0, 1'b0);
    #1;
    chk("rs_pc_stall", hz.pc_stall, 1'b1);
    tick();
    chk("rs_stall_cnt", hz.stall_cnt, PERF ? 16'd2 : 16'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("rs_async_pc_stall", hz.pc_stall,    1'b0);
    chk("rs_async_bubble",   hz.idex_bubble, 1'b0);
    chk("rs_async_fwd_a",    hz.fwd_a_sel,   2'b00);
    chk("rs_async_stall_cnt", hz.stall_cnt,  16'd0);
    chk("rs_async_flush_cnt", hz.flush_cnt,  16'd0);
    tick();
    rst = 1'b0;
    instr(4'd13, 1'b1, 4'd12, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("rs_reader_no_stall", hz.pc_stall, 1'b0);
    tick();
    chk("rs_reader_fwd_a", hz.fwd_a_sel, 2'b00);
    chk("rs_reader_fwd_b", hz.fwd_b_sel, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
